dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the shared single-port data memory of the riscv core. It multiplexes the core's load/store port and a debug/loader port onto the one memory interface (`wr`, `rd`, `addr`, `wr_data`, `rd_data`). Each access is a single-word request/acknowledge transaction run by a three-state FSM. It sits between the riscv datapath and the data memory; the testbench memory monitor watches its memory-side signals.

## Interface
- `ADDR_W`, default 9: word address width, giving a 512-word memory.
- `DATA_W`, default 32: data width.

- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `core_req` in 1: core access request; held until `core_ack`.
- `core_we` in 1: 1 for a store, 0 for a load; stable while `core_req` is high.
- `core_addr` in ADDR_W: core word address.
- `core_wdata` in DATA_W: core store data.
- `core_rdata` out DATA_W: core load data; valid when `core_ack` is high, held until the next core load completes.
- `core_ack` out 1: one-cycle completion pulse to the core.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: the same signal set and rules for the debug/loader port.
- `wr` out 1: memory write strobe.
- `rd` out 1: memory read strobe.
- `addr` out ADDR_W: memory address.
- `wr_data` out DATA_W: memory write data.
- `rd_data` in DATA_W: memory read data, valid one cycle after `rd`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states.
  - IDLE: if either request is high, arbitrate, latch the winner's id, `we`, `addr` and `wdata` into registers, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive the memory from the latched registers. `wr` = `we`, `rd` = ~`we`, exactly one strobe high. Go to RESP.
  - RESP: for a read, capture `rd_data` into the winner's `*_rdata` register. Pulse the winner's `*_ack`. Go to IDLE.
- Arbitration, default: fixed priority, core beats debug. Round-robin is available via the Configuration macro.
- The loser's request is not dropped. The loser must keep `*_req` high and is served on a later pass through IDLE.
- The memory-side outputs come only from the latched registers. Requester fields that change after latching have no effect on the transaction in flight.
- In IDLE and RESP, `wr` = `rd` = 0 and `addr`/`wr_data` hold their last values. `wr` and `rd` are never high at the same time.
- A write does not modify `*_rdata`.
- Once latched, the requester's id, operation and fields are not re-checked; the transaction completes even if the requester drops `*_req` mid-transaction.
- A requester that keeps `*_req` high in the cycle after its ack is treated as issuing a new request.

## Timing
- Reset values, applied asynchronously:
  - State = IDLE.
  - `wr`, `rd`, `core_ack`, `dbg_ack`, `busy` = 0.
  - `addr`, `wr_data`, `core_rdata`, `dbg_rdata` = 0.
  - Round-robin pointer = core.
- Reset asserted mid-transaction aborts it at once: no ack and no strobe, and the memory write is lost if reset arrives before the ACCESS edge.
- Latency:
  - Request sampled high at edge N, with the FSM in IDLE.
  - `wr`/`rd` high during cycle N+1.
  - `*_ack` high during cycle N+2 together with valid `*_rdata`.
  - FSM back in IDLE at edge N+3.
- Throughput is one access per 3 cycles. Two back-to-back requesters therefore see acks 3 cycles apart.
- Both requests high at the same edge in IDLE: exactly one winner, chosen per the arbitration policy.
- A request arriving while `busy` is high waits; it is sampled at the first IDLE edge.

## Configuration
- `DMEM_ARB_RR_EN`
  - Defined: round-robin arbitration.
    - A 1-bit pointer names the port that wins a tie.
    - When a grant is issued, the pointer moves to the other port.
    - Without a tie, the single requester wins and the pointer still moves to the other port.
  - Undefined: fixed priority, core always wins a tie. The pointer logic is removed.

## Test plan
- Core store, then load:
  - Stimulus: core_req with core_we=1, core_addr=9'd20, core_wdata=32'hDEADBEEF, then a load from 20.
  - Required: `wr` high for exactly 1 cycle with addr=20, core_ack 2 cycles after each request edge, core_rdata=32'hDEADBEEF.
- Debug load, one cycle after reset release:
  - Stimulus: dbg load from address 511, memory preloaded with 32'h12345678.
  - Required: `rd` pulse with addr=511, dbg_ack with dbg_rdata=32'h12345678, core_rdata stays 0.
- Simultaneous requests, fixed priority:
  - Stimulus: core and debug both request in the same cycle.
  - Required: core_ack at N+2, dbg_ack at N+5, `wr` and `rd` never both high.
- Sustained contention, `DMEM_ARB_RR_EN` defined:
  - Stimulus: both ports hold their requests for 4 transactions.
  - Required: ack order is core, dbg, core, dbg.
- Reset during ACCESS:
  - Stimulus: assert reset while a core store is in ACCESS.
  - Required: all outputs 0 immediately, no core_ack, state IDLE. A new request after reset completes normally.
- Field change after latch:
  - Stimulus: change core_addr from 5 to 6 during ACCESS.
  - Required: memory `addr` remains 5 for the whole transaction.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core and debug/loader ports share one single-port data memory, one word per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise fixed priority with core winning.
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_ack,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_ack,
  output logic              o_wr,
  output logic              o_rd,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam logic ID_CORE = 1'b0;
  localparam logic ID_DBG  = 1'b1;

  state_t            r_state, w_state_nxt;
  logic              r_id, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data, r_core_rdata, r_dbg_rdata;
  logic              w_grant, w_win_id;
  logic              w_wr, w_rd, w_core_ack, w_dbg_ack, w_rd_done;

`ifdef DMEM_ARB_RR_EN
  logic r_ptr;

  // The pointer only breaks ties; every grant hands the next tie to the other port.
  always_comb begin
    w_win_id = ID_CORE;
    if (i_core_req && i_dbg_req) w_win_id = r_ptr;
    else if (i_dbg_req)          w_win_id = ID_DBG;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_ptr <= ID_CORE;
    else if (w_grant) r_ptr <= ~w_win_id;
  end
`else
  assign w_win_id = i_core_req ? ID_CORE : ID_DBG;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_core_ack  = 1'b0;
    w_dbg_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_core_req || i_dbg_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_wr        = r_we;
        w_rd        = ~r_we;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_core_ack  = (r_id == ID_CORE);
        w_dbg_ack   = (r_id == ID_DBG);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read data arrives during RESP; pass it straight through with the ack, then hold it.
  assign w_rd_done = (r_state == S_RESP) && !r_we;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_id         <= ID_CORE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_core_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_id      <= w_win_id;
        r_we      <= (w_win_id == ID_CORE) ? i_core_we    : i_dbg_we;
        r_addr    <= (w_win_id == ID_CORE) ? i_core_addr  : i_dbg_addr;
        r_wr_data <= (w_win_id == ID_CORE) ? i_core_wdata : i_dbg_wdata;
      end
      if (w_rd_done && (r_id == ID_CORE)) r_core_rdata <= i_rd_data;
      if (w_rd_done && (r_id == ID_DBG))  r_dbg_rdata  <= i_rd_data;
    end
  end

  assign o_core_rdata = (w_rd_done && (r_id == ID_CORE)) ? i_rd_data : r_core_rdata;
  assign o_dbg_rdata  = (w_rd_done && (r_id == ID_DBG))  ? i_rd_data : r_dbg_rdata;
  assign o_core_ack   = w_core_ack;
  assign o_dbg_ack    = w_dbg_ack;
  assign o_wr         = w_wr;
  assign o_rd         = w_rd;
  assign o_addr       = r_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = (r_state != S_IDLE);

endmodule
